// File: rtl/uart_pkg.sv
// Shared defaults and drain FSM encoding for the UART transmit buffer.
package uart_pkg;
  localparam int WIDTH_DEF = 8;
  localparam int DEPTH_DEF = 16;
  localparam int AW_DEF    = $clog2(DEPTH_DEF);

  typedef enum logic {
    IDLE      = 1'b0,
    WAIT_BUSY = 1'b1
  } tx_state_e;
endpackage

// File: rtl/sync_fifo_core.sv
// Single-clock FIFO: register array, wrapping pointers, separate fill counter,
// full/empty decode and a sticky overflow flag for dropped pushes.
module sync_fifo_core
  import uart_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW    = AW_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic             clr_ovf,
  output logic [WIDTH-1:0] rd_data,
  output logic [AW:0]      count,
  output logic             empty,
  output logic             full,
  output logic             ovf
);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             r_ovf;
  logic             w_push;
  logic             w_pop;

  // Full check uses the pre-edge count, so a push at full is dropped even
  // when a pop happens in the same cycle.
  assign w_push  = wr_en & ~full;
  assign w_pop   = rd_en & ~empty;
  assign empty   = (r_count == '0);
  assign full    = (r_count == (AW+1)'(DEPTH));
  assign count   = r_count;
  assign ovf     = r_ovf;
  assign rd_data = r_mem[r_rd_ptr];

  // Storage write; contents need no reset since count gates every read.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= wr_data;
  end

  // Pointers wrap modulo DEPTH; count tracks occupancy independently.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Sticky overflow: a dropped push beats a simultaneous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)               r_ovf <= 1'b0;
    else if (wr_en && full)  r_ovf <= 1'b1;
    else if (clr_ovf)        r_ovf <= 1'b0;
  end
endmodule

// File: rtl/uart_tx_fifo.sv
// Transmit buffer in front of the UART engine: processor pushes bytes into a
// FIFO, a two-state drain FSM hands them over with a load/txrdy handshake.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW    = AW_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             clr_ovf,
  input  logic             txrdy,
  output logic             load,
  output logic [WIDTH-1:0] tx_data,
  output logic [AW:0]      count,
  output logic             empty,
  output logic             full,
  output logic             ovf,
  output logic             tbe
);
  tx_state_e        r_state;
  tx_state_e        w_state_nxt;
  logic             w_pop;
  logic [WIDTH-1:0] w_rd_data;
  logic             r_load;
  logic [WIDTH-1:0] r_tx_data;

  sync_fifo_core #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_core (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .rd_en   (w_pop),
    .clr_ovf (clr_ovf),
    .rd_data (w_rd_data),
    .count   (count),
    .empty   (empty),
    .full    (full),
    .ovf     (ovf)
  );

  // Drain state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next state and pop decision. empty is registered, so a byte pushed into
  // an empty FIFO pops one cycle later (no write-to-read bypass). WAIT_BUSY
  // holds off a second load until the engine has visibly dropped txrdy.
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    case (r_state)
      IDLE: begin
        if (!empty && txrdy) begin
          w_pop       = 1'b1;
          w_state_nxt = WAIT_BUSY;
        end
      end
      WAIT_BUSY: begin
        if (!txrdy) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Registered load pulse and byte; tx_data holds until the next pop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_load    <= 1'b0;
      r_tx_data <= '0;
    end else begin
      r_load <= w_pop;
      if (w_pop) r_tx_data <= w_rd_data;
    end
  end

  assign load    = r_load;
  assign tx_data = r_tx_data;
  assign tbe     = empty & txrdy & (r_state == IDLE);
endmodule
